mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
- Sequencing controller for the multicycle MIPS datapath: a Moore FSM plus an ALU decoder that drives the shared-memory, IR, register-file, ALU and PC enables.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j over 3-5 cycles per instruction.
- Sits beside the datapath; decodes opcode/funct from the IR and zero from the ALU.

Parameters:
- none (opcode, funct and state encodings are fixed in the package)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  IR load enable
- RegDst  out  1  write register select: 1=rd, 0=rt
- MemtoReg  out  1  write data select: 1=Data, 0=ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- PCSrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load = PCWrite | (Branch & zero)
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode or R-type funct

Behaviour:
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 go to FETCH on the next edge.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP, other->FETCH.
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
  - EXECUTE->ALUWB; ADDIEX->ADDIWB.
- Moore outputs (unlisted outputs are 0):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, Branch=1, PCSrc=01, ALUOp=01.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALU decode (combinational): ALUOp 00->010, 01->110. ALUOp 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
- illegal_op asserts in DECODE when the opcode is not in the supported set, or when opcode=000000 and funct is unsupported. An unsupported R-type funct still proceeds to EXECUTE.
- instr_done asserts in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP.
- Latency (FETCH to FETCH): lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Reset:
  - State is forced to FETCH asynchronously.
  - While reset_n=0, IRWrite, PCEn, RegWrite, MemWrite, instr_done and illegal_op are forced to 0 combinationally.
  - Other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no partial write occurs after reset asserts.
- opcode and zero are sampled only in the states that use them. zero is relevant only in BRANCH, where PCEn=zero.

Decomposition:
- Package mips_multicycle_pkg holds:
  - the state_t enum;
  - opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_ADDI 001000, OP_J 000010);
  - funct constants;
  - ALUControl constants;
  - the ALUOp encoding.
- One sub-module, mips_multicycle_alu_decoder (ALUOp and funct in, ALUControl out). FSM and output decode stay in the top module.

Test Plan:
- Hold reset_n=0 for 3 cycles -> state=FETCH, IRWrite=0, PCEn=0; release -> first edge gives FETCH outputs IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010.
- opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB has RegWrite=1, MemtoReg=1, instr_done=1; 5 cycles total.
- opcode=101011 -> MEMWR has MemWrite=1, IorD=1; opcode=000000 with funct=101010 -> EXECUTE ALUControl=111, then ALUWB RegDst=1, RegWrite=1.
- opcode=000100 in BRANCH: zero=1 -> PCEn=1, PCSrc=01, ALUControl=110; zero=0 -> PCEn=0; return to FETCH after 3 cycles either way.
- opcode=000010 -> JUMP has PCSrc=10, PCEn=1. opcode=111111 -> illegal_op=1 in DECODE, then FETCH, no write enables asserted.
- Assert reset_n=0 mid-MEMADR of lw -> state=FETCH immediately; MemWrite and RegWrite never assert; after release, normal fetch resumes.

Source files
------------

// File: rtl/mips_multicycle_pkg.sv
// -----------------------------------------------------------------------------
// mips_multicycle_pkg
// Shared definitions for the multicycle MIPS controller:
//   - state_t       : 4-bit FSM state encoding
//   - OP_* / F_*    : supported opcode and R-type funct values
//   - ALU_*         : ALUControl encodings
//   - aluop_t       : ALUOp encoding passed from the FSM to the ALU decoder
//   - ctrl_t        : bundle of Moore control bits produced per state
// -----------------------------------------------------------------------------
package mips_multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        aluop_t     alu_op;
        logic       instr_done;
    } ctrl_t;

    // Moore control word for a given state; anything not set stays 0.
    function automatic ctrl_t ctrl_for_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.memto_reg  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.branch     = 1'b1;
                c.pc_src     = 2'b01;
                c.alu_op     = ALUOP_SUB;
                c.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic funct_supported(input logic [5:0] fn);
        case (fn)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_alu_decoder.sv
// -----------------------------------------------------------------------------
// mips_multicycle_alu_decoder
// Combinational ALU control decode.
//   alu_op      in  2  ALUOp from the controller FSM
//   funct       in  6  IR[5:0], consulted only when alu_op selects funct decode
//   alu_control out 3  ALU operation select
// -----------------------------------------------------------------------------
module mips_multicycle_alu_decoder
    import mips_multicycle_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    // Unsupported funct is flagged in DECODE; the ALU just adds.
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// -----------------------------------------------------------------------------
// mips_multicycle_controller
// Moore sequencing FSM plus ALU decode for the multicycle MIPS datapath.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   opcode, funct, zero   IR[31:26], IR[5:0], ALU zero flag
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], PCSrc[1:0], PCEn, ALUControl[2:0]   datapath controls
//   instr_done            pulse in the last state of each instruction
//   illegal_op            pulse in DECODE for unsupported opcode/funct
// -----------------------------------------------------------------------------
module mips_multicycle_controller
    import mips_multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    logic   decode_illegal;

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            // Final states and unused encodings 12-15 all return to FETCH.
            default:   state_next = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state (decoded from the next
    // state) so every Moore output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
            ctrl_reg  <= ctrl_for_state(S_FETCH);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for_state(state_next);
        end
    end

    assign decode_illegal = !op_supported(opcode) ||
                            ((opcode == OP_RTYPE) && !funct_supported(funct));

    mips_multicycle_alu_decoder u_alu_decoder (
        .alu_op      (ctrl_reg.alu_op),
        .funct       (funct),
        .alu_control (ALUControl)
    );

    assign IorD     = ctrl_reg.iord;
    assign RegDst   = ctrl_reg.reg_dst;
    assign MemtoReg = ctrl_reg.memto_reg;
    assign ALUSrcA  = ctrl_reg.alu_src_a;
    assign ALUSrcB  = ctrl_reg.alu_src_b;
    assign PCSrc    = ctrl_reg.pc_src;

    // State-changing enables are gated by reset_n so nothing is written
    // while reset is held, even before the async reset settles the flops.
    assign IRWrite    = reset_n & ctrl_reg.ir_write;
    assign MemWrite   = reset_n & ctrl_reg.mem_write;
    assign RegWrite   = reset_n & ctrl_reg.reg_write;
    assign PCEn       = reset_n & (ctrl_reg.pc_write | (ctrl_reg.branch & zero));
    assign instr_done = reset_n & ctrl_reg.instr_done;
    assign illegal_op = reset_n & (state_reg == S_DECODE) & decode_illegal;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_controller
// Directed bench: each task walks one instruction type through the FSM and
// compares the full packed output vector against hand-written per-state
// expectations at every step.
// Vector order: {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//                ALUSrcB[1:0], PCSrc[1:0], PCEn, ALUControl[2:0],
//                instr_done, illegal_op}
// -----------------------------------------------------------------------------
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn;
    logic [2:0] ALUControl;
    logic       instr_done, illegal_op;
    logic [16:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    mips_multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, PCSrc, PCEn, ALUControl, instr_done, illegal_op};

    //                          IorD  MemW  IRW   RDst  M2R   RegW  SrcA  SrcB   PCSrc  PCEn  ALUCtl  done  ill
    localparam logic [16:0] E_RESET   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_FETCH   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_DECODE  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_DEC_ILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0, 1'b1};
    localparam logic [16:0] E_MEMADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMRD   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1, 1'b0};
    localparam logic [16:0] E_MEMWR   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1, 1'b0};
    localparam logic [16:0] E_EXEC_ADD= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_EXEC_SUB= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b110, 1'b0, 1'b0};
    localparam logic [16:0] E_EXEC_AND= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [16:0] E_EXEC_OR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0};
    localparam logic [16:0] E_EXEC_SLT= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b111, 1'b0, 1'b0};
    localparam logic [16:0] E_ALUWB   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1, 1'b0};
    localparam logic [16:0] E_BR_T    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 3'b110, 1'b1, 1'b0};
    localparam logic [16:0] E_BR_NT   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 3'b110, 1'b1, 1'b0};
    localparam logic [16:0] E_ADDIEX  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    localparam logic [16:0] E_ADDIWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1, 1'b0};
    localparam logic [16:0] E_JUMP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'b010, 1'b1, 1'b0};

    // Hold reset for 3 cycles, then release and expect live FETCH outputs.
    task automatic test_reset();
        reset_n = 1'b0;
        opcode  = 6'b000000;
        funct   = 6'b000000;
        zero    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (obs !== E_RESET) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d: got %b expected %b", i, obs, E_RESET);
            end
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== E_FETCH) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", obs, E_FETCH);
        end
        $display("test_reset: done");
    endtask

    task automatic test_lw();
        logic [16:0] exp_seq [6];
        exp_seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL lw step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 5) @(negedge clk);
        end
        $display("test_lw: 5-cycle sequence checked");
    endtask

    task automatic test_sw();
        logic [16:0] exp_seq [5];
        exp_seq = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        opcode = 6'b101011; funct = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL sw step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
        $display("test_sw: 4-cycle sequence checked");
    endtask

    task automatic test_rtype();
        logic [5:0]  fn_tab   [5];
        logic [16:0] exec_tab [5];
        logic [16:0] exp_seq  [5];
        fn_tab   = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
        exec_tab = '{E_EXEC_SLT, E_EXEC_ADD, E_EXEC_SUB, E_EXEC_AND, E_EXEC_OR};
        for (int k = 0; k < 5; k++) begin
            exp_seq = '{E_FETCH, E_DECODE, exec_tab[k], E_ALUWB, E_FETCH};
            opcode = 6'b000000; funct = fn_tab[k]; zero = 1'b0;
            for (int i = 0; i < 5; i++) begin
                #1;
                n_cmp++;
                if (obs !== exp_seq[i]) begin
                    n_err++;
                    $display("FAIL rtype funct=%b step %0d: got %b expected %b",
                             fn_tab[k], i, obs, exp_seq[i]);
                end
                if (i < 4) @(negedge clk);
            end
            $display("test_rtype: funct=%b checked", fn_tab[k]);
        end
    endtask

    // Unsupported funct: flagged in DECODE, but still executes as an add.
    task automatic test_rtype_bad_funct();
        logic [16:0] exp_seq [5];
        exp_seq = '{E_FETCH, E_DEC_ILL, E_EXEC_ADD, E_ALUWB, E_FETCH};
        opcode = 6'b000000; funct = 6'b111111; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL rtype_bad_funct step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
        $display("test_rtype_bad_funct: checked");
    endtask

    task automatic test_beq();
        logic [16:0] exp_seq [4];
        for (int t = 0; t < 2; t++) begin
            exp_seq = '{E_FETCH, E_DECODE, (t == 0) ? E_BR_T : E_BR_NT, E_FETCH};
            opcode = 6'b000100; funct = 6'b000000; zero = (t == 0);
            for (int i = 0; i < 4; i++) begin
                #1;
                n_cmp++;
                if (obs !== exp_seq[i]) begin
                    n_err++;
                    $display("FAIL beq zero=%0d step %0d: got %b expected %b", zero, i, obs, exp_seq[i]);
                end
                if (i < 3) @(negedge clk);
            end
            $display("test_beq: zero=%0d checked", zero);
        end
        zero = 1'b0;
    endtask

    task automatic test_addi();
        logic [16:0] exp_seq [5];
        exp_seq = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
        opcode = 6'b001000; funct = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL addi step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
        $display("test_addi: checked");
    endtask

    task automatic test_jump();
        logic [16:0] exp_seq [4];
        exp_seq = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        opcode = 6'b000010; funct = 6'b000000; zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL jump step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 3) @(negedge clk);
        end
        zero = 1'b0;
        $display("test_jump: checked");
    endtask

    task automatic test_illegal();
        logic [16:0] exp_seq [3];
        exp_seq = '{E_FETCH, E_DEC_ILL, E_FETCH};
        opcode = 6'b111111; funct = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL illegal step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 2) @(negedge clk);
        end
        $display("test_illegal: checked");
    endtask

    // Reset asserted while lw sits in MEMADR: abandon without any write.
    task automatic test_reset_mid();
        logic [16:0] exp_seq [3];
        exp_seq = '{E_FETCH, E_DECODE, E_MEMADR};
        opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++;
                $display("FAIL reset_mid pre step %0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 2) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== E_RESET) begin
            n_err++;
            $display("FAIL reset_mid assert: got %b expected %b", obs, E_RESET);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({MemWrite, RegWrite, obs} !== {2'b00, E_RESET}) begin
                n_err++;
                $display("FAIL reset_mid hold cyc %0d: got %b expected %b", i, obs, E_RESET);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== E_FETCH) begin
            n_err++;
            $display("FAIL reset_mid release: got %b expected %b", obs, E_FETCH);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== E_DECODE) begin
            n_err++;
            $display("FAIL reset_mid resume: got %b expected %b", obs, E_DECODE);
        end
        $display("test_reset_mid: checked");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_rtype_bad_funct();
        test_beq();
        test_addi();
        test_jump();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
